tdm_demux8_1: RTL and testbench
===============================

# tdm_demux8_1

Receive-side counterpart of the 8:1 channel multiplexer. It takes the time-division-multiplexed serial stream produced by the mux side, with one bit per channel slot and a frame marker in slot 0. It tracks the slot sequence with a counter and a lock state machine, reassembles each frame into a parallel word, and presents it atomically. It sits between the serial link and the per-channel consumers.

## Interface
- N_CH, 8, channels per frame; power of two, 2..16.
- SEL_W, $clog2(N_CH), width of the slot index.
- MISS_LIMIT, 2, consecutive slot-0 samples without Frame before lock is dropped; range 1..15.

- Clock  in  1  single clock, all logic on its rising edge.
- Reset  in  1  synchronous reset, active-high.
- Din  in  1  serial data bit for the current slot.
- Valid  in  1  Din and Frame are sampled only when Valid=1.
- Frame  in  1  frame marker; high with the slot-0 bit.
- Dout  out  N_CH  last complete frame; bit k = channel k.
- Dout_valid  out  1  one-cycle pulse when Dout is updated.
- Sel  out  SEL_W  slot index the next Valid bit will be stored as.
- Locked  out  1  1 in state LOCKED.
- Sync_err  out  1  one-cycle pulse on a misplaced Frame.

## Operation
- Reset value of all outputs is 0. The state machine enters HUNT. The slot counter, shadow register and miss counter are cleared.
- **HUNT:**
  - A Valid with Frame=0 is ignored.
  - A Valid with Frame=1 stores Din in shadow[0], sets slot to 1 and moves to LOCKED.
- **LOCKED, Valid=1 at slot s>0 with Frame=0:**
  - Store Din in shadow[s] and increment the slot counter.
  - At s=N_CH-1 the slot counter wraps to 0. Dout receives the shadow register with the current bit merged in, and Dout_valid pulses.
- **LOCKED, Valid=1 at slot 0:**
  - If Frame=1, clear the miss counter, store the bit and set slot to 1.
  - If Frame=0, increment the miss counter.
    - If it is now below MISS_LIMIT, the bit is stored as channel 0 and the frame proceeds normally (flywheel).
    - If it reaches MISS_LIMIT, move to HUNT, discard the bit, set slot to 0 and clear the miss counter.
- **LOCKED, Valid=1 at slot s>0 with Frame=1:**
  - Sync_err pulses and the partial frame is discarded; Dout is unchanged and there is no Dout_valid.
  - The current bit becomes shadow[0], slot is set to 1, the miss counter is cleared, and the state stays LOCKED.
- **Valid=0:** no state, counter or output changes; pulse outputs return to 0.
- Dout holds its value between updates. It is never partially updated.
- Sel equals the slot counter. It is 0 in HUNT.

## Timing
- Latency is 1 cycle. Dout and Dout_valid change on the edge that samples the channel N_CH-1 bit, so they are visible in the following cycle.
- Back-to-back frames are supported, with Valid high every cycle (throughput 1 bit/cycle). Dout_valid then pulses once every N_CH cycles.
- Sync_err and Dout_valid are never high in the same cycle.
- Locked rises in the cycle after the first Valid&Frame in HUNT. It falls in the cycle after the MISS_LIMIT-th miss.
- Reset asserted mid-frame:
  - On the next edge all state returns to reset values and the partial frame is lost.
  - Reset overrides Valid in the same cycle.

## Configuration
- TDM_DEMUX_ERRCNT_EN
  - Defined: adds output Err_cnt (out, 8 bits, reset 0). It increments saturating at 255 on each Sync_err pulse and on each transition LOCKED->HUNT caused by misses. It is cleared only by Reset.
  - Undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- Reset, then Valid=1 continuously with Frame=1 every 8th cycle and channel bits 1,0,1,1,0,0,1,0 -> Locked=1 after the first bit. Dout=8'b01001101 with a single Dout_valid pulse one cycle after the 8th bit, repeating every 8 cycles.
- Valid toggling 1/0 with the same frame -> identical Dout, with Dout_valid 16 cycles after the first bit. Sel advances only on Valid cycles.
- Locked stream, Frame asserted at slot 3 -> Sync_err pulses once, no Dout_valid for the aborted frame, Sel=1 next cycle. The next full frame is decoded correctly.
- Locked stream with MISS_LIMIT=2, Frame dropped on one slot 0 -> Locked stays 1 and that frame is decoded. Frame dropped on two consecutive frames -> Locked=0 and Sel=0 after the second miss, with relock on the next Frame.
- Reset pulsed at slot 5 -> all outputs 0 and state HUNT next cycle. No Dout_valid until a new Frame plus 8 bits.
- With TDM_DEMUX_ERRCNT_EN: 3 misplaced Frames and 1 miss-induced unlock -> Err_cnt=4. 300 Sync_err events -> Err_cnt=255.

Source files
------------

// File: rtl/tdm_demux8_1.sv
// tdm_demux8_1: TDM serial stream to parallel frame demultiplexer with frame-marker lock tracking.
// Optional saturating error counter output o_err_cnt when TDM_DEMUX_ERRCNT_EN is defined.
module tdm_demux8_1 #(
    parameter int N_CH       = 8,
    parameter int SEL_W      = $clog2(N_CH),
    parameter int MISS_LIMIT = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_din,
    input  logic             i_valid,
    input  logic             i_frame,
    output logic [N_CH-1:0]  o_dout,
    output logic             o_dout_valid,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_locked,
`ifdef TDM_DEMUX_ERRCNT_EN
    output logic [7:0]       o_err_cnt,
`endif
    output logic             o_sync_err
);
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t            r_state, w_state_n;
    logic [SEL_W-1:0]  r_slot, w_slot_n;
    logic [N_CH-1:0]   r_shadow, w_shadow_n, w_merged, r_dout, w_dout_n;
    logic [3:0]        r_miss, w_miss_n;
    logic              r_dv, w_dv_n, r_serr, w_serr_n, w_unlock, w_restart;

    always_comb begin
        w_state_n          = r_state;
        w_slot_n           = r_slot;
        w_shadow_n         = r_shadow;
        w_miss_n           = r_miss;
        w_dout_n           = r_dout;
        w_dv_n             = 1'b0;
        w_serr_n           = 1'b0;
        w_unlock           = 1'b0;
        w_restart          = 1'b0;
        w_merged           = r_shadow;
        w_merged[r_slot]   = i_din;
        if (i_valid) begin
            if (r_state == HUNT) begin
                w_restart = i_frame;
            end else if (r_slot == '0) begin
                if (i_frame) begin
                    w_restart = 1'b1;
                end else if (r_miss + 4'd1 >= 4'(MISS_LIMIT)) begin
                    w_state_n = HUNT;
                    w_slot_n  = '0;
                    w_miss_n  = '0;
                    w_unlock  = 1'b1;
                end else begin
                    w_miss_n   = r_miss + 4'd1;
                    w_shadow_n = w_merged;
                    w_slot_n   = SEL_W'(1);
                end
            end else if (i_frame) begin
                w_serr_n  = 1'b1;
                w_restart = 1'b1;
            end else begin
                w_shadow_n = w_merged;
                w_slot_n   = r_slot + 1'b1;
                w_dv_n     = (r_slot == SEL_W'(N_CH - 1));
                w_dout_n   = w_dv_n ? w_merged : r_dout;
            end
        end
        // A frame marker (in HUNT, at slot 0, or misplaced) starts a fresh frame with this bit as channel 0
        if (w_restart) begin
            w_state_n  = LOCKED;
            w_shadow_n = {r_shadow[N_CH-1:1], i_din};
            w_slot_n   = SEL_W'(1);
            w_miss_n   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= HUNT;
            r_slot   <= '0;
            r_shadow <= '0;
            r_miss   <= '0;
            r_dout   <= '0;
            r_dv     <= 1'b0;
            r_serr   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_slot   <= w_slot_n;
            r_shadow <= w_shadow_n;
            r_miss   <= w_miss_n;
            r_dout   <= w_dout_n;
            r_dv     <= w_dv_n;
            r_serr   <= w_serr_n;
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] r_err_cnt;
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_err_cnt <= '0;
        else if ((w_serr_n | w_unlock) && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end
    assign o_err_cnt = r_err_cnt;
`endif

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dv;
    assign o_sel        = r_slot;
    assign o_locked     = (r_state == LOCKED);
    assign o_sync_err   = r_serr;
endmodule

// File: tb/tb_tdm_demux8_1.sv
// tb_tdm_demux8_1: vector-table bench for tdm_demux8_1 (lock, flywheel, sync error, reset, back-to-back frames).
module tb_tdm_demux8_1;
    typedef struct {
        logic       rst, v, f, d;
        logic [7:0] dout;
        logic       dv;
        logic [2:0] sel;
        logic       lk, se;
    } vec_t;

    vec_t       vq[$];
    logic       clk = 1'b0, rst = 1'b0, din = 1'b0, valid = 1'b0, frame = 1'b0;
    logic [7:0] dout;
    logic       dv, locked, serr;
    logic [2:0] sel;
    logic [7:0] p1 = 8'h4D, p2 = 8'h96;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif
    int checks = 0, errors = 0;

    tdm_demux8_1 dut (
        .i_clk(clk), .i_rst(rst), .i_din(din), .i_valid(valid), .i_frame(frame),
        .o_dout(dout), .o_dout_valid(dv), .o_sel(sel), .o_locked(locked),
`ifdef TDM_DEMUX_ERRCNT_EN
        .o_err_cnt(err_cnt),
`endif
        .o_sync_err(serr)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, v, f, d, input logic [7:0] o, input logic ov,
                       input logic [2:0] s, input logic l, e);
        vq.push_back('{r, v, f, d, o, ov, s, l, e});
    endtask

    // One locked frame from slot k0; Dout moves from prev to nw on the last bit
    task automatic add_frame(input logic [7:0] ch, input logic f0, input logic [7:0] prev, nw, input int k0);
        for (int k = k0; k < 8; k++)
            add(1'b0, 1'b1, f0 && k == 0, ch[k], k == 7 ? nw : prev, k == 7, 3'((k + 1) % 8), 1'b1, 1'b0);
    endtask

    task automatic add_gap_frame(input logic [7:0] ch, input logic [7:0] prev, nw);
        for (int k = 0; k < 8; k++) begin
            add(1'b0, 1'b1, k == 0, ch[k], k == 7 ? nw : prev, k == 7, 3'((k + 1) % 8), 1'b1, 1'b0);
            add(1'b0, 1'b0, 1'b1, ~ch[k], k == 7 ? nw : prev, 1'b0, 3'((k + 1) % 8), 1'b1, 1'b0);
        end
    endtask

    task automatic step(input logic r, v, f, d);
        rst = r; valid = v; frame = f; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        int np;
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 1, 8'h00, 0, 0, 0, 0);
        add(0, 0, 1, 1, 8'h00, 0, 0, 0, 0);
        add_frame(p1, 1, 8'h00, 8'h4D, 0);
        add_frame(p1, 1, 8'h4D, 8'h4D, 0);
        add_gap_frame(p1, 8'h4D, 8'h4D);
        // misplaced Frame at slot 3
        add(0, 1, 1, p2[0], 8'h4D, 0, 1, 1, 0);
        add(0, 1, 0, p2[1], 8'h4D, 0, 2, 1, 0);
        add(0, 1, 0, p2[2], 8'h4D, 0, 3, 1, 0);
        add(0, 1, 1, p2[0], 8'h4D, 0, 1, 1, 1);
        add_frame(p2, 0, 8'h4D, 8'h96, 1);
        add_frame(p2, 1, 8'h96, 8'h96, 0);
        // misplaced Frame on the last slot: no Dout update
        for (int k = 0; k < 7; k++) add(0, 1, k == 0, p1[k], 8'h96, 0, 3'(k + 1), 1, 0);
        add(0, 1, 1, p1[0], 8'h96, 0, 1, 1, 1);
        add_frame(p1, 0, 8'h96, 8'h4D, 1);
        // single miss flywheels, a good Frame clears, two misses unlock
        add_frame(p2, 0, 8'h4D, 8'h96, 0);
        add_frame(p1, 1, 8'h96, 8'h4D, 0);
        add_frame(p2, 0, 8'h4D, 8'h96, 0);
        for (int k = 0; k < 8; k++) add(0, 1, 0, p1[k], 8'h96, 0, 0, 0, 0);
        add_frame(p1, 1, 8'h96, 8'h4D, 0);
        // reset at slot 5 overrides a Valid Frame
        for (int k = 0; k < 5; k++) add(0, 1, k == 0, p2[k], 8'h4D, 0, 3'(k + 1), 1, 0);
        add(1, 1, 1, 1, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 1, 8'h00, 0, 0, 0, 0);
        add_frame(p2, 1, 8'h00, 8'h96, 0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].v, vq[i].f, vq[i].d);
            chk($sformatf("vec%0d", i), {18'd0, dout, dv, sel, locked, serr},
                {18'd0, vq[i].dout, vq[i].dv, vq[i].sel, vq[i].lk, vq[i].se});
        end

        // back-to-back frames: one pulse per 8 cycles
        step(1, 0, 0, 0);
        np = 0;
        for (int fr = 0; fr < 4; fr++)
            for (int k = 0; k < 8; k++) begin
                step(0, 1, k == 0, p2[k]);
                chk($sformatf("b2b_dv%0d_%0d", fr, k), {31'd0, dv}, {31'd0, k == 7});
                if (dv) begin
                    np++;
                    chk("b2b_dout", {24'd0, dout}, {24'd0, p2});
                end
            end
        chk("b2b_pulses", np, 4);

`ifdef TDM_DEMUX_ERRCNT_EN
        step(1, 0, 0, 0);
        chk("errcnt_reset", {24'd0, err_cnt}, 32'd0);
        step(0, 1, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        chk("errcnt_unlock", {31'd0, locked}, 32'd0);
        chk("errcnt_4", {24'd0, err_cnt}, 32'd4);
        step(0, 1, 1, 1);
        for (int i = 0; i < 300; i++) step(0, 1, 1, 1);
        chk("errcnt_sat", {24'd0, err_cnt}, 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
